// File: rtl/rr_mux_arbiter_pkg.sv
// rr_arb_pkg: shared state type, pointer-width helper and one-hot decoder for the round-robin mux arbiter
package rr_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    localparam int MAX_INPUTS = 16;
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_INPUTS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_INPUTS; i++) idx = oh[i] ? 4'(i) : idx;
        return idx;
    endfunction
endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// rr_pick: combinational round-robin picker (rotate by ptr, find first set, rotate back)
//   req   : request vector
//   ptr   : index where the search starts
//   excl  : requesters removed from the search (the current owner)
//   pick  : one-hot winner, zero when nothing is eligible
//   found : at least one eligible requester
module rr_pick #(
    parameter int INPUTS = 4,
    parameter int PTR_W  = 2
) (
    input  logic [INPUTS-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    input  logic [INPUTS-1:0] excl,
    output logic [INPUTS-1:0] pick,
    output logic              found
);
    logic [INPUTS-1:0]   cand, rot, first;
    logic [2*INPUTS-1:0] rot_w, back_w;
    always_comb begin
        cand   = req & ~excl;
        rot_w  = {cand, cand} >> ptr;
        rot    = rot_w[INPUTS-1:0];
        first  = rot & (~rot + INPUTS'(1));
        back_w = {first, first} << ptr;
        pick   = back_w[2*INPUTS-1:INPUTS];
        found  = |cand;
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one WIDTH-bit lane among INPUTS requesters
//   clk, rst : clock and synchronous active-high reset
//   req      : level-sensitive requests
//   data_in  : lane i at [i*WIDTH +: WIDTH]
//   grant    : registered one-hot grant, zero when idle
//   data_out : data of the granted lane, zero when idle
//   valid    : OR of grant
//   RR_ARB_HOLD_LIMIT_EN : when defined, an owner is rotated out after MAX_HOLD cycles if others wait
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int INPUTS   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INPUTS-1:0]         req,
    input  logic [WIDTH*INPUTS-1:0]   data_in,
    output logic [INPUTS-1:0]         grant,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid
);
    localparam int PTR_W = ptr_width(INPUTS);

    arb_state_t        state_q, state_d;
    logic [INPUTS-1:0] grant_q, grant_d, pick;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              found, owner_req, rotate, at_limit;
    logic [3:0]        pick_idx;

    // ptr always sits one past the last winner, so it is also the k+1 start
    // for handover; excluding grant_q keeps the owner out of the search
    rr_pick #(.INPUTS(INPUTS), .PTR_W(PTR_W)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .excl  (grant_q),
        .pick  (pick),
        .found (found)
    );

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = ptr_width(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    assign at_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    // restarts at the limit too, so a lone owner gets a fresh window
    assign hold_cnt_d = (rotate || at_limit) ? '0 : hold_cnt_q + HOLD_W'(1);
    always_ff @(posedge clk) begin
        if (rst) hold_cnt_q <= '0;
        else     hold_cnt_q <= hold_cnt_d;
    end
`else
    assign at_limit = 1'b0;
`endif

    always_comb begin
        owner_req = |(req & grant_q);
        pick_idx  = onehot_to_idx(MAX_INPUTS'(pick));
        rotate    = (state_q == ARB_IDLE) || !owner_req || (at_limit && found);
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        if (rotate) begin
            state_d = found ? ARB_GRANT : ARB_IDLE;
            grant_d = found ? pick : '0;
            ptr_d   = found ? PTR_W'((int'(pick_idx) + 1) % INPUTS) : ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < INPUTS; i++)
            data_out = data_out | (data_in[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
    end

    assign grant = grant_q;
    assign valid = |grant_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench for rr_mux_arbiter (4 lanes of 4 bits)
module tb_rr_mux_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b1111;
    logic [15:0] data_in = {4'hC, 4'hA, 4'h5, 4'h3};
    logic [3:0]  grant;
    logic [3:0]  data_out;
    logic        valid;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];

    rr_mux_arbiter #(.WIDTH(4), .INPUTS(4), .MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .data_out (data_out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lane_val(input logic [3:0] g);
        return g == 4'b0001 ? 4'h3 : g == 4'b0010 ? 4'h5 : g == 4'b0100 ? 4'hA : g == 4'b1000 ? 4'hC : 4'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] g;
        for (int i = 0; i < 5; i++) begin
            rst = (i < 3);
            req = (i < 4) ? 4'b1111 : 4'b0000;
            exp_q.push_back(i == 3 ? 4'b0001 : 4'b0000);
            tick();
            g = exp_q.pop_front();
            checks++;
            if (grant !== g || valid !== (|g) || data_out !== lane_val(g)) begin
                failures++;
                $display("FAIL reset cyc=%0d grant=%b valid=%b data_out=%h expected grant=%b data_out=%h", i, grant, valid, data_out, g, lane_val(g));
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] g;
        for (int i = 0; i < 11; i++) begin
            req = (i < 10) ? 4'b0100 : 4'b0000;
            exp_q.push_back((i < 10) ? 4'b0100 : 4'b0000);
            tick();
            g = exp_q.pop_front();
            checks++;
            if (grant !== g || valid !== (|g) || data_out !== lane_val(g)) begin
                failures++;
                $display("FAIL single cyc=%0d grant=%b valid=%b data_out=%h expected grant=%b data_out=%h", i, grant, valid, data_out, g, lane_val(g));
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] reqs[11] = '{4'b0000, 4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                 4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111};
        logic [3:0] exps[11] = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        logic [3:0] g;
        for (int i = 0; i < 11; i++) begin
            rst = (i == 0);
            req = reqs[i];
            exp_q.push_back(exps[i]);
            tick();
            g = exp_q.pop_front();
            checks++;
            if (grant !== g || valid !== (|g) || data_out !== lane_val(g)) begin
                failures++;
                $display("FAIL fairness cyc=%0d grant=%b valid=%b data_out=%h expected grant=%b data_out=%h", i, grant, valid, data_out, g, lane_val(g));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] reqs[5] = '{4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000};
        logic [3:0] exps[5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
        logic [3:0] g;
        for (int i = 0; i < 5; i++) begin
            req = reqs[i];
            exp_q.push_back(exps[i]);
            tick();
            g = exp_q.pop_front();
            checks++;
            if (grant !== g || valid !== (|g) || data_out !== lane_val(g)) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d grant=%b valid=%b data_out=%h expected grant=%b data_out=%h", i, grant, valid, data_out, g, lane_val(g));
            end
        end
    endtask

`ifdef RR_ARB_HOLD_LIMIT_EN
    task automatic test_hold_limit();
        logic [3:0] g;
        for (int i = 0; i < 54; i++) begin
            rst = (i == 0);
            req = (i == 0 || i == 53) ? 4'b0000 : (i <= 32) ? 4'b0011 : 4'b0001;
            exp_q.push_back((i == 0 || i == 53) ? 4'b0000 :
                            (i > 32) ? 4'b0001 :
                            (((i - 1) / 8) % 2 == 0) ? 4'b0001 : 4'b0010);
            tick();
            g = exp_q.pop_front();
            checks++;
            if (grant !== g || valid !== (|g) || data_out !== lane_val(g)) begin
                failures++;
                $display("FAIL hold_limit cyc=%0d grant=%b valid=%b data_out=%h expected grant=%b data_out=%h", i, grant, valid, data_out, g, lane_val(g));
            end
        end
        rst = 1'b0;
    endtask
`else
    task automatic test_no_hold_limit();
        logic [3:0] g;
        for (int i = 0; i < 27; i++) begin
            rst = (i == 0);
            req = (i == 0 || i == 26) ? 4'b0000 : 4'b0011;
            exp_q.push_back((i == 0 || i == 26) ? 4'b0000 : 4'b0001);
            tick();
            g = exp_q.pop_front();
            checks++;
            if (grant !== g || valid !== (|g) || data_out !== lane_val(g)) begin
                failures++;
                $display("FAIL no_hold_limit cyc=%0d grant=%b valid=%b data_out=%h expected grant=%b data_out=%h", i, grant, valid, data_out, g, lane_val(g));
            end
        end
        rst = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        logic [3:0] rsts  = 4'b0000;
        logic [3:0] reqs[7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] exps[7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        logic [3:0] g;
        rsts = 4'b1001;
        for (int i = 0; i < 7; i++) begin
            rst = (i < 4) ? rsts[i] : 1'b0;
            req = reqs[i];
            exp_q.push_back(exps[i]);
            tick();
            g = exp_q.pop_front();
            checks++;
            if (grant !== g || valid !== (|g) || data_out !== lane_val(g)) begin
                failures++;
                $display("FAIL mid_reset cyc=%0d grant=%b valid=%b data_out=%h expected grant=%b data_out=%h", i, grant, valid, data_out, g, lane_val(g));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
`ifdef RR_ARB_HOLD_LIMIT_EN
        test_hold_limit();
`else
        test_no_hold_limit();
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
